// File: rtl/multicycle_control.sv
// multicycle_control
//
// Main sequencer and ALU decoder for the multicycle RISC-V datapath. A
// Moore-style FSM walks each instruction through fetch, decode, execute,
// memory and write-back. It drives every datapath strobe and mux select from
// the current state. The only exceptions are FETCH, whose IR/PC loads wait
// for mem_ready, and BEQ, whose PC load follows the zero flag.
// Opcodes and funct3 values that are not supported trap into ILLEGAL. The
// FSM stays there until reset.
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high reset
//   op, funct3, funct7b5 instruction fields from the latched IR
//   zero                 ALU result equals zero
//   mem_ready            memory access completes this cycle
//   mem_write            data memory write strobe
//   reg_write            register file write strobe
//   ir_write             IR load
//   pc_write             PC load from alu_out
//   instruction_or_data  address select: 0 = PC, 1 = result
//   result_src           00 alu_out, 01 read data, 10 alu_result
//   alu_src_a            00 pc, 01 rs1, 10 old_pc
//   alu_src_b            00 rs2, 01 const 4, 10 imm, 11 zero
//   alu_control          000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal              sticky trap flag
//   instr_count          instructions fetched, wraps modulo 2^CNT_W
//   state_dbg            current state encoding
//
// State table
//   state    | meaning
//   FETCH    | read instruction at PC; on mem_ready load IR and PC <= PC + 4
//   DECODE   | alu_out <= old_pc + imm (branch/jump target), pick the class
//   MEMADR   | alu_out <= rs1 + imm (load/store address)
//   MEMREAD  | read data memory at alu_out until mem_ready
//   MEMWB    | rd <= read data
//   MEMWRITE | write data memory at alu_out until mem_ready
//   EXECUTER | alu_out <= rs1 op rs2
//   EXECUTEI | alu_out <= rs1 op imm
//   ALUWB    | rd <= alu_out
//   BEQ      | compare rs1 - rs2; on zero take the target left by DECODE
//   JAL      | PC <= target, alu_out <= old_pc + 4 for the link write
//   ILLEGAL  | trapped; all strobes low until reset

module multicycle_control #(
    parameter int CNT_W             = 32,
    parameter int RESET_STATE_FETCH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_write,
    output logic             reg_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             instruction_or_data,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    // Only a FETCH boot state exists today; other values are reserved.
    if (RESET_STATE_FETCH != 1) begin : g_reset_state_check
        $error("multicycle_control: only RESET_STATE_FETCH = 1 is supported");
    end

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] RES_ALU_OUT  = 2'b00;
    localparam logic [1:0] RES_RDATA    = 2'b01;
    localparam logic [1:0] RES_ALU_RSLT = 2'b10;

    state_t           state;
    state_t           state_next;
    state_t           decode_target;
    logic             funct3_ok;
    logic [2:0]       alu_dec;

    logic             mem_write_s;
    logic             reg_write_s;
    logic             ir_write_s;
    logic             pc_write_s;

    // ALU decoder: funct3 picks the operation, and funct7b5 splits add/sub
    // only for R-type. I-type addi can carry imm[10] = 1 in the funct7b5
    // position, so op[5] gates it.
    always_comb begin
        alu_dec   = ALU_ADD;
        funct3_ok = 1'b1;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: funct3_ok = 1'b0;
        endcase
    end

    // Instruction class seen in DECODE. An unsupported opcode, or an
    // unsupported funct3 on an arithmetic op, traps.
    always_comb begin
        decode_target = ILLEGAL;
        case (op)
            OP_LOAD,
            OP_STORE:  decode_target = MEMADR;
            OP_RTYPE:  decode_target = funct3_ok ? EXECUTER : ILLEGAL;
            OP_ITYPE:  decode_target = funct3_ok ? EXECUTEI : ILLEGAL;
            OP_BRANCH: decode_target = BEQ;
            OP_JAL:    decode_target = JAL;
            default:   decode_target = ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        mem_write_s         = 1'b0;
        reg_write_s         = 1'b0;
        ir_write_s          = 1'b0;
        pc_write_s          = 1'b0;
        instruction_or_data = 1'b0;
        result_src          = RES_ALU_OUT;
        alu_src_a           = SRC_A_PC;
        alu_src_b           = SRC_B_RS2;
        alu_control         = ALU_ADD;

        case (state)
            FETCH: begin
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU_RSLT;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_IMM;
                state_next = decode_target;
            end
            MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                instruction_or_data = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_s = 1'b1;
                state_next  = FETCH;
            end
            MEMWRITE: begin
                // Strobe held through the whole wait so slow memories see it.
                instruction_or_data = 1'b1;
                mem_write_s         = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end
            end
            EXECUTER: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                alu_control = alu_dec;
                state_next  = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_IMM;
                alu_control = alu_dec;
                state_next  = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                state_next  = FETCH;
            end
            BEQ: begin
                // alu_out still holds the DECODE target; the subtraction
                // only feeds zero.
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                alu_control = ALU_SUB;
                pc_write_s  = zero;
                state_next  = FETCH;
            end
            JAL: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                pc_write_s = 1'b1;
                state_next = ALUWB;
            end
            ILLEGAL: begin
                state_next = ILLEGAL;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // No architectural state may change while reset is held, even in the
    // cycle before the state register has settled to FETCH.
    assign mem_write = mem_write_s & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign ir_write  = ir_write_s  & ~reset;
    assign pc_write  = pc_write_s  & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (state_next == ILLEGAL) begin
            illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (state == FETCH && mem_ready) begin
            instr_count <= instr_count + 1'b1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  alu_control;
    logic        illegal;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    multicycle_control #(.CNT_W(32), .RESET_STATE_FETCH(1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .op                  (op),
        .funct3              (funct3),
        .funct7b5            (funct7b5),
        .zero                (zero),
        .mem_ready           (mem_ready),
        .mem_write           (mem_write),
        .reg_write           (reg_write),
        .ir_write            (ir_write),
        .pc_write            (pc_write),
        .instruction_or_data (instruction_or_data),
        .result_src          (result_src),
        .alu_src_a           (alu_src_a),
        .alu_src_b           (alu_src_b),
        .alu_control         (alu_control),
        .illegal             (illegal),
        .instr_count         (instr_count),
        .state_dbg           (state_dbg)
    );

    always #5 clk = ~clk;

    // Observed bundle: state, mw, rw, irw, pcw, iod, rs, a, b, alu, illegal.
    typedef struct packed {
        logic [3:0] st;
        logic       mw, rw, irw, pcw, iod;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        logic       ill;
    } obs_t;

    typedef struct {
        obs_t e;
        logic mr;
    } cyc_t;

    typedef enum int {
        K_LW, K_SW, K_ADD, K_SUB, K_SLT, K_OR, K_AND,
        K_ADDI, K_SLTI, K_ORI, K_ANDI, K_BEQ, K_JAL, K_BAD
    } kind_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         st_after_decode;
        int         alu;
        int         cycles;
    } vec_t;

    obs_t  obs;
    cyc_t  trace[$];
    vec_t  vecs[18];
    int    tests = 0;
    int    fails = 0;
    int    model_cnt = 0;
    int    mw_cnt = 0;
    logic [2:0] bad_f3 [4] = '{3'b001, 3'b011, 3'b100, 3'b101};

    assign obs = {state_dbg, mem_write, reg_write, ir_write, pc_write,
                  instruction_or_data, result_src, alu_src_a, alu_src_b,
                  alu_control, illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic int alu_of(input kind_t k);
        case (k)
            K_SUB:         return 1;
            K_SLT, K_SLTI: return 5;
            K_OR,  K_ORI:  return 3;
            K_AND, K_ANDI: return 2;
            default:       return 0;
        endcase
    endfunction

    task automatic encode(input kind_t k, input int bad_sel,
                          output logic [6:0] o, output logic [2:0] f3, output logic f7);
        int sel;
        f3 = 3'($urandom_range(0, 7));
        f7 = rb();
        o  = 7'b1111111;
        case (k)
            K_LW:   o = 7'b0000011;
            K_SW:   o = 7'b0100011;
            K_BEQ:  o = 7'b1100011;
            K_JAL:  o = 7'b1101111;
            K_ADD:  begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b0; end
            K_SUB:  begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
            K_SLT:  begin o = 7'b0110011; f3 = 3'b010; f7 = 1'b0; end
            K_OR:   begin o = 7'b0110011; f3 = 3'b110; f7 = 1'b0; end
            K_AND:  begin o = 7'b0110011; f3 = 3'b111; f7 = 1'b0; end
            K_ADDI: begin o = 7'b0010011; f3 = 3'b000; end
            K_SLTI: begin o = 7'b0010011; f3 = 3'b010; end
            K_ORI:  begin o = 7'b0010011; f3 = 3'b110; end
            K_ANDI: begin o = 7'b0010011; f3 = 3'b111; end
            default: begin
                sel = (bad_sel > 3) ? int'($urandom_range(0, 3)) : bad_sel;
                case (sel)
                    0:       o = 7'b1111111;
                    1:       o = 7'b0110111;
                    2:       begin o = 7'b0110011; f3 = bad_f3[$urandom_range(0, 3)]; end
                    default: begin o = 7'b0010011; f3 = bad_f3[$urandom_range(0, 3)]; end
                endcase
            end
        endcase
    endtask

    // Arguments: state, mem_ready to drive, iod, result_src, src_a, src_b, alu,
    // mem_write, reg_write, ir_write, pc_write, illegal.
    task automatic push(input int st, input int mr, input int iod, input int rs,
                        input int a, input int b, input int alu, input int mw,
                        input int rw, input int irw, input int pcw, input int ill);
        cyc_t c;
        c.e  = {4'(st), 1'(mw), 1'(rw), 1'(irw), 1'(pcw), 1'(iod),
                2'(rs), 2'(a), 2'(b), 3'(alu), 1'(ill)};
        c.mr = 1'(mr);
        trace.push_back(c);
    endtask

    // Called and returns just after a falling edge.
    task automatic run_trace();
        foreach (trace[i]) begin
            mem_ready = trace[i].mr;
            #1;
            chk($sformatf("trace step %0d state %0d", i, trace[i].e.st),
                32'(obs), 32'(trace[i].e));
            if (mem_write) mw_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("strobes during reset", 32'({mem_write, reg_write, ir_write, pc_write}), 32'd0);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        chk("state after reset", 32'(state_dbg), 32'd0);
        chk("illegal after reset", 32'(illegal), 32'd0);
        chk("instr_count after reset", instr_count, 32'd0);
        model_cnt = 0;
    endtask

    // Expected per-cycle behaviour of one whole instruction, with fs fetch
    // stalls and ms memory stalls; runs it and checks the fetch counter.
    task automatic run_instr(input kind_t k, input logic z, input int fs,
                             input int ms, input int bad_sel);
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;
        int         ao;
        encode(k, bad_sel, o, f3, f7);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        ao = alu_of(k);
        trace.delete();
        for (int i = 0; i < fs; i++) push(0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 2, 0, 1, 0, 0, 0, 1, 1, 0);
        push(1, rb(), 0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        case (k)
            K_LW: begin
                push(2, rb(), 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
                for (int i = 0; i < ms; i++) push(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(4, rb(), 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
            end
            K_SW: begin
                push(2, rb(), 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
                for (int i = 0; i < ms; i++) push(5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
                push(5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            end
            K_ADD, K_SUB, K_SLT, K_OR, K_AND: begin
                push(6, rb(), 0, 0, 1, 0, ao, 0, 0, 0, 0, 0);
                push(8, rb(), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            end
            K_ADDI, K_SLTI, K_ORI, K_ANDI: begin
                push(7, rb(), 0, 0, 1, 2, ao, 0, 0, 0, 0, 0);
                push(8, rb(), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            end
            K_BEQ: push(9, rb(), 0, 0, 1, 0, 1, 0, 0, 0, int'(z), 0);
            K_JAL: begin
                push(10, rb(), 0, 0, 2, 1, 0, 0, 0, 0, 1, 0);
                push(8, rb(), 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            end
            default: for (int i = 0; i < 10; i++) push(15, rb(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        endcase
        model_cnt++;
        run_trace();
        chk($sformatf("instr_count after kind %0d", k), instr_count, 32'(model_cnt));
        if (k == K_BAD) do_reset();
    endtask

    // Advance n cycles from FETCH with mem_ready high, then assert reset.
    task automatic reset_at(input kind_t k, input int n, input int exp_st);
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;
        encode(k, 0, o, f3, f7);
        op = o; funct3 = f3; funct7b5 = f7; zero = 1'b0;
        mem_ready = 1'b1;
        repeat (n) @(negedge clk);
        #1;
        chk("state before mid-instruction reset", 32'(state_dbg), 32'(exp_st));
        reset = 1'b1;
        #1;
        chk("strobes during mid-instruction reset",
            32'({mem_write, reg_write, ir_write, pc_write}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("state after mid-instruction reset", 32'(state_dbg), 32'd0);
        chk("illegal after mid-instruction reset", 32'(illegal), 32'd0);
        chk("count after mid-instruction reset", instr_count, 32'd0);
        model_cnt = 0;
    endtask

    task automatic setv(input int i, input string n, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7, input int st,
                        input int alu, input int cyc);
        vecs[i] = '{n, o, f3, f7, st, alu, cyc};
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // name, op, funct3, funct7b5, state after DECODE, alu in execute, total cycles
        setv(0,  "lw",        7'b0000011, 3'b010, 1'b0, 2,  0, 5);
        setv(1,  "sw",        7'b0100011, 3'b010, 1'b1, 2,  0, 4);
        setv(2,  "add",       7'b0110011, 3'b000, 1'b0, 6,  0, 4);
        setv(3,  "sub",       7'b0110011, 3'b000, 1'b1, 6,  1, 4);
        setv(4,  "slt",       7'b0110011, 3'b010, 1'b0, 6,  5, 4);
        setv(5,  "or",        7'b0110011, 3'b110, 1'b0, 6,  3, 4);
        setv(6,  "and",       7'b0110011, 3'b111, 1'b0, 6,  2, 4);
        setv(7,  "r f3 001",  7'b0110011, 3'b001, 1'b0, 15, 0, 0);
        setv(8,  "addi b30",  7'b0010011, 3'b000, 1'b1, 7,  0, 4);
        setv(9,  "slti",      7'b0010011, 3'b010, 1'b0, 7,  5, 4);
        setv(10, "ori",       7'b0010011, 3'b110, 1'b0, 7,  3, 4);
        setv(11, "andi",      7'b0010011, 3'b111, 1'b0, 7,  2, 4);
        setv(12, "i f3 101",  7'b0010011, 3'b101, 1'b0, 15, 0, 0);
        setv(13, "beq",       7'b1100011, 3'b000, 1'b0, 9,  0, 3);
        setv(14, "jal",       7'b1101111, 3'b000, 1'b0, 10, 0, 4);
        setv(15, "op 1111111",7'b1111111, 3'b000, 1'b0, 15, 0, 0);
        setv(16, "op 0000000",7'b0000000, 3'b000, 1'b0, 15, 0, 0);
        setv(17, "lui",       7'b0110111, 3'b000, 1'b0, 15, 0, 0);

        @(negedge clk);
        do_reset();

        foreach (vecs[v]) begin
            int cycles;
            do_reset();
            op = vecs[v].op; funct3 = vecs[v].f3; funct7b5 = vecs[v].f7;
            zero = 1'b0; mem_ready = 1'b1;
            @(negedge clk); #1;
            chk({vecs[v].name, " decode state"}, 32'(state_dbg), 32'd1);
            @(negedge clk); #1;
            chk({vecs[v].name, " next state"}, 32'(state_dbg), 32'(vecs[v].st_after_decode));
            if (vecs[v].st_after_decode == 6 || vecs[v].st_after_decode == 7)
                chk({vecs[v].name, " alu_control"}, 32'(alu_control), 32'(vecs[v].alu));
            if (vecs[v].st_after_decode == 15) begin
                repeat (3) @(negedge clk);
                #1;
                chk({vecs[v].name, " stays trapped"}, 32'(state_dbg), 32'd15);
                chk({vecs[v].name, " illegal"}, 32'(illegal), 32'd1);
            end else begin
                cycles = 2;
                while (state_dbg != 4'd0 && cycles < 20) begin
                    @(negedge clk); #1;
                    cycles++;
                end
                chk({vecs[v].name, " cycles"}, 32'(cycles), 32'(vecs[v].cycles));
                chk({vecs[v].name, " count"}, instr_count, 32'd1);
            end
        end

        do_reset();
        run_instr(K_LW, 1'b0, 0, 2, 0);
        run_instr(K_SUB, 1'b0, 0, 0, 0);
        run_instr(K_BEQ, 1'b1, 0, 0, 0);
        run_instr(K_BEQ, 1'b0, 1, 0, 0);
        mw_cnt = 0;
        run_instr(K_SW, 1'b0, 0, 3, 0);
        chk("sw mem_write cycles", 32'(mw_cnt), 32'd4);
        run_instr(K_JAL, 1'b0, 2, 0, 0);
        run_instr(K_BAD, 1'b0, 0, 0, 0);
        reset_at(K_SUB, 2, 6);
        reset_at(K_LW, 4, 4);
        reset_at(K_BAD, 3, 15);

        for (int n = 0; n < 200; n++) begin
            int    r;
            kind_t k;
            r = int'($urandom_range(0, 15));
            k = (r >= 13) ? K_BAD : kind_t'(r);
            if (r == 14) k = K_LW;
            run_instr(k, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
